sdp_ram_be: RTL and testbench
=============================

SDP_RAM_BE -- requirements
Module: sdp_ram_be

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, number of words (any value >= 2).
REQ-003 The block SHALL have parameter BYTE_W, default 8, lane width; WIDTH SHALL be an integer multiple of BYTE_W, and NB = WIDTH/BYTE_W.
REQ-004 The block SHALL have parameter READ_LATENCY, default 1, read latency in cycles, legal values 1 or 2.
REQ-005 The block SHALL have parameter RDW_MODE, default 0, read-during-write result: 0 = old data, 1 = new data.
REQ-006 The block SHALL have parameter CLEAR_ON_RESET, default 1, where 1 = zero all words after reset.
REQ-007 The block SHALL derive ADDR = clog2(DEPTH), minimum 1.
REQ-008 The block SHALL use one clock; reset is synchronous and active-high.
REQ-009 clk  in  1  clock, rising-edge active for all logic.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 write_en  in  1  write request.
REQ-012 write_addr  in  ADDR  write word address.
REQ-013 write_data  in  WIDTH  write data.
REQ-014 write_be  in  NB  byte-lane enables; bit i covers bits [i*BYTE_W +: BYTE_W].
REQ-015 read_en  in  1  read request.
REQ-016 read_addr  in  ADDR  read word address.
REQ-017 read_data  out  WIDTH  registered read data.
REQ-018 read_valid  out  1  one-cycle pulse, high when read_data carries a new result.
REQ-019 busy  out  1  high while the clear sequence is running; requests are ignored while high.

Function
REQ-020 Write: at a rising edge with write_en=1, busy=0 and write_addr<DEPTH, the block SHALL update only those lanes whose write_be bit is 1; write_be=0 SHALL leave memory unchanged.
REQ-021 Read: read_en=1 sampled at edge N with busy=0 SHALL give read_valid=1 and read_data at edge N+READ_LATENCY; each read SHALL produce exactly one pulse.
REQ-022 Reads SHALL be fully pipelined, accepting one per cycle with no bubbles.
REQ-023 read_data SHALL hold its last value when read_valid=0.
REQ-024 Same-cycle write and read to the same address: RDW_MODE=0 SHALL return the pre-write word; RDW_MODE=1 SHALL return enabled lanes from write_data and the other lanes from the old word.
REQ-025 Out-of-range address (>=DEPTH, when DEPTH is not a power of 2): the write SHALL be dropped; the read SHALL return all-zero data with read_valid=1.
REQ-026 Clear FSM states: IDLE and CLEAR. While rst=1, state=CLEAR and clear counter=0, with no memory writes.
REQ-027 In CLEAR with rst=0, each edge SHALL write zero to mem[counter] and increment the counter. After the edge that writes DEPTH-1, the FSM SHALL go to IDLE.
REQ-028 busy SHALL equal (state==CLEAR), giving exactly DEPTH busy cycles after rst deasserts.
REQ-029 CLEAR_ON_RESET=0: reset SHALL go directly to IDLE; busy SHALL be 0 after reset; memory contents SHALL be unchanged.
REQ-030 write_en and read_en asserted while busy=1 SHALL be discarded, not queued.
REQ-031 The counter SHALL stop at DEPTH-1 and never wrap.

Reset
REQ-032 With rst=1 at an edge: read_data=0, read_valid=0, all in-flight read pipeline stages flushed, and busy=CLEAR_ON_RESET.
REQ-033 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-034 Reset asserted mid-read SHALL produce no read_valid pulse for reads accepted before the reset.

Structure
REQ-035 Shared package mem_pkg SHALL hold the clog2 function and RDW_OLD=0 / RDW_NEW=1 constants.
REQ-036 The clear FSM and counter SHALL be the sub-module mem_clear_seq (outputs busy, clr_we, clr_addr).
REQ-037 The storage array SHALL stay in sdp_ram_be and SHALL be written from one always block, with a clear-versus-user write mux.

Verification
REQ-038 Reset then release, DEPTH=16, CLEAR_ON_RESET=1: busy high exactly 16 cycles; then a read of every address -> 0, one read_valid each.
REQ-039 Write addr 3 data 0xAABBCCDD be=4'b1111, then addr 3 data 0x11223344 be=4'b0101 -> read addr 3 returns 0xAA22CC44.
REQ-040 Same-cycle write/read addr 5 (old word 0x0, new 0xFFFFFFFF, be=1111) -> RDW_MODE=0 returns 0x0; RDW_MODE=1 returns 0xFFFFFFFF.
REQ-041 READ_LATENCY=2, back-to-back reads of addrs 0,1,2 -> three consecutive read_valid pulses, starting 2 cycles after the first request, data in order.
REQ-042 Assert rst at clear counter=7, release -> busy high a further 16 cycles; a write issued while busy is dropped (later read returns 0).
REQ-043 DEPTH=12: write to addr 13 is ignored; read addr 13 -> read_data 0, read_valid 1.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Definitions shared by the simple-dual-port RAM and its clear sequencer:
//   - clog2()      : ceiling log2, used to size address buses
//   - RDW_OLD/NEW  : read-during-write result selection
//   - clr_state_t  : states of the post-reset clear sequencer
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Smallest r such that 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// -----------------------------------------------------------------------------
// mem_clear_seq
// Walks an address counter over every word after reset so the RAM can zero
// itself one word per clock.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   busy     out  high while the clear sequence owns the memory
//   clr_we   out  write strobe for the zeroing write (never while rst=1)
//   clr_addr out  word currently being zeroed
// -----------------------------------------------------------------------------
module mem_clear_seq
   import mem_pkg::*;
#(
   parameter int DEPTH          = 16,
   parameter int ADDR           = 4,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic            clk,
   input  logic            rst,
   output logic            busy,
   output logic            clr_we,
   output logic [ADDR-1:0] clr_addr
);

   localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);

   clr_state_t      state;
   logic [ADDR-1:0] count;

   // Reset parks the counter at word 0; a reset arriving mid-clear therefore
   // restarts the sweep. The counter stops on the last word instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         count <= '0;
      end else if (state == CLEAR) begin
         if (count == LAST) begin
            state <= IDLE;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   assign busy     = (state == CLEAR);
   // Holding rst keeps the state in CLEAR but must not touch memory.
   assign clr_we   = busy && !rst;
   assign clr_addr = count;

endmodule

// File: rtl/sdp_ram_be.sv
// -----------------------------------------------------------------------------
// sdp_ram_be
// Simple dual-port RAM (one write port, one read port, one clock) with
// byte-lane write enables, 1- or 2-cycle registered reads, selectable
// read-during-write behaviour and an optional zero-fill after reset.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   write_en   in   write request
//   write_addr in   write word address
//   write_data in   write data
//   write_be   in   byte-lane enables, bit i -> bits [i*BYTE_W +: BYTE_W]
//   read_en    in   read request
//   read_addr  in   read word address
//   read_data  out  registered read data, held between results
//   read_valid out  one-cycle pulse per accepted read
//   busy       out  clear sequence running; requests are discarded
// -----------------------------------------------------------------------------
module sdp_ram_be
   import mem_pkg::*;
#(
   parameter  int WIDTH          = 32,
   parameter  int DEPTH          = 16,
   parameter  int BYTE_W         = 8,
   parameter  int READ_LATENCY   = 1,
   parameter  int RDW_MODE       = 0,
   parameter  int CLEAR_ON_RESET = 1,
   localparam int NB             = WIDTH / BYTE_W,
   localparam int ADDR           = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_en,
   input  logic [ADDR-1:0]   write_addr,
   input  logic [WIDTH-1:0]  write_data,
   input  logic [NB-1:0]     write_be,
   input  logic              read_en,
   input  logic [ADDR-1:0]   read_addr,
   output logic [WIDTH-1:0]  read_data,
   output logic              read_valid,
   output logic              busy
);

   // One extra bit so the range compare also works when DEPTH == 2**ADDR.
   localparam logic [ADDR:0] DEPTH_L = (ADDR + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic             clr_we;
   logic [ADDR-1:0]  clr_addr;
   logic             wr_in_range;
   logic             rd_in_range;
   logic             wr_fire;
   logic             rd_fire;
   logic [WIDTH-1:0] lane_mask;
   logic [WIDTH-1:0] old_word;
   logic [WIDTH-1:0] rd_word;

   mem_clear_seq #(
      .DEPTH          (DEPTH),
      .ADDR           (ADDR),
      .CLEAR_ON_RESET (CLEAR_ON_RESET)
   ) u_clear (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign wr_in_range = ({1'b0, write_addr} < DEPTH_L);
   assign rd_in_range = ({1'b0, read_addr} < DEPTH_L);

   // Requests are discarded outright while clearing or in reset.
   assign wr_fire = write_en && !busy && !rst && wr_in_range;
   assign rd_fire = read_en && !busy && !rst;

   // Expand the byte enables to a bit mask, used for read-during-write merging.
   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < NB; i++) begin
         lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{write_be[i]}};
      end
   end

   // Single write process: the clear sequencer and user writes never overlap
   // because user writes require busy=0, so clear simply takes priority.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < NB; i++) begin
            if (write_be[i]) begin
               mem[write_addr][i*BYTE_W +: BYTE_W] <= write_data[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Out-of-range reads return zero. In new-data mode a same-address write in
   // the same cycle overrides only its enabled lanes.
   always_comb begin
      old_word = '0;
      if (rd_in_range) begin
         old_word = mem[read_addr];
      end
      rd_word = old_word;
      if ((RDW_MODE != RDW_OLD) && wr_fire && (write_addr == read_addr)) begin
         rd_word = (old_word & ~lane_mask) | (write_data & lane_mask);
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic             s1_valid;
         logic [WIDTH-1:0] s1_data;

         // Two-stage read pipeline; reset flushes both stages.
         always_ff @(posedge clk) begin
            if (rst) begin
               s1_valid   <= 1'b0;
               s1_data    <= '0;
               read_valid <= 1'b0;
               read_data  <= '0;
            end else begin
               s1_valid   <= rd_fire;
               read_valid <= s1_valid;
               if (rd_fire) begin
                  s1_data <= rd_word;
               end
               if (s1_valid) begin
                  read_data <= s1_data;
               end
            end
         end
      end else begin : g_lat1
         // Single-stage read; read_data only moves when a result arrives.
         always_ff @(posedge clk) begin
            if (rst) begin
               read_valid <= 1'b0;
               read_data  <= '0;
            end else begin
               read_valid <= rd_fire;
               if (rd_fire) begin
                  read_data <= rd_word;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sdp_ram_be.sv
// -----------------------------------------------------------------------------
// tb_sdp_ram_be
// Drives two RAM instances with identical stimulus:
//   dut_a : DEPTH=16, READ_LATENCY=1, RDW_MODE=old
//   dut_b : DEPTH=12, READ_LATENCY=2, RDW_MODE=new
// A word-array model per instance predicts each read result and pushes it on
// a per-instance queue; a negedge monitor pops and compares every pulse, and
// also checks busy and read_data hold every cycle.
// -----------------------------------------------------------------------------
module tb_sdp_ram_be;

   typedef struct packed {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_en;
   logic [3:0]  write_addr;
   logic [31:0] write_data;
   logic [3:0]  write_be;
   logic        read_en;
   logic [3:0]  read_addr;

   logic [31:0] read_data_a, read_data_b;
   logic        read_valid_a, read_valid_b;
   logic        busy_a, busy_b;

   logic [31:0] model_mem [2][16];
   int          clr_left [2];
   logic [31:0] last_data [2];
   exp_t        exp_q0 [$];
   exp_t        exp_q1 [$];

   int edge_cnt   = 0;
   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   sdp_ram_be #(
      .WIDTH(32), .DEPTH(16), .BYTE_W(8),
      .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
   ) dut_a (
      .clk(clk), .rst(rst),
      .write_en(write_en), .write_addr(write_addr),
      .write_data(write_data), .write_be(write_be),
      .read_en(read_en), .read_addr(read_addr),
      .read_data(read_data_a), .read_valid(read_valid_a), .busy(busy_a)
   );

   sdp_ram_be #(
      .WIDTH(32), .DEPTH(12), .BYTE_W(8),
      .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
   ) dut_b (
      .clk(clk), .rst(rst),
      .write_en(write_en), .write_addr(write_addr),
      .write_data(write_data), .write_be(write_be),
      .read_en(read_en), .read_addr(read_addr),
      .read_data(read_data_b), .read_valid(read_valid_b), .busy(busy_b)
   );

   function automatic int depth_of(input int k);
      return (k == 0) ? 16 : 12;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 2;
   endfunction

   function automatic bit new_data_of(input int k);
      return (k != 0);
   endfunction

   // Byte-lane merge: enabled lanes come from nw, the rest from old.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] mask;
      mask = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) mask = mask | (32'hFF << (8 * i));
      end
      return (old & ~mask) | (nw & mask);
   endfunction

   // Apply the inputs present at this rising edge to both models.
   task automatic model_edge();
      logic [31:0] rd;
      bit          wr_ok;
      exp_t        e;
      edge_cnt++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            clr_left[k]  = depth_of(k);
            last_data[k] = 32'h0;
            for (int i = 0; i < 16; i++) model_mem[k][i] = 32'h0;
            if (k == 0) exp_q0.delete();
            else        exp_q1.delete();
         end else if (clr_left[k] > 0) begin
            clr_left[k]--;
         end else begin
            wr_ok = write_en && (int'(write_addr) < depth_of(k));
            if (read_en) begin
               rd = (int'(read_addr) < depth_of(k)) ? model_mem[k][read_addr] : 32'h0;
               if (wr_ok && new_data_of(k) && (write_addr == read_addr))
                  rd = merge(rd, write_data, write_be);
               e.data = rd;
               e.due  = edge_cnt + lat_of(k) - 1;
               if (k == 0) exp_q0.push_back(e);
               else        exp_q1.push_back(e);
            end
            if (wr_ok)
               model_mem[k][write_addr] = merge(model_mem[k][write_addr], write_data, write_be);
         end
      end
   endtask

   task automatic cmp(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s dut%0d edge %0d: got %h expected %h", name, k, edge_cnt, act, exp);
      end
   endtask

   task automatic check_output(input int k, input logic v, input logic [31:0] d,
                               input logic b);
      exp_t e;
      bit   have;
      have = 1'b0;
      e    = '0;
      if (k == 0 && exp_q0.size() > 0 && exp_q0[0].due == edge_cnt) begin
         e = exp_q0.pop_front(); have = 1'b1;
      end
      if (k == 1 && exp_q1.size() > 0 && exp_q1[0].due == edge_cnt) begin
         e = exp_q1.pop_front(); have = 1'b1;
      end
      cmp("busy", k, 32'(b), 32'(clr_left[k] > 0));
      cmp("read_valid", k, 32'(v), 32'(have));
      if (have) begin
         cmp("read_data", k, d, e.data);
         last_data[k] = e.data;
      end else begin
         cmp("read_data_hold", k, d, last_data[k]);
      end
   endtask

   always @(negedge clk) begin
      if (edge_cnt > 0) begin
         check_output(0, read_valid_a, read_data_a, busy_a);
         check_output(1, read_valid_b, read_data_b, busy_b);
      end
   end

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic apply_stimulus(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic [3:0] be, input bit re, input logic [3:0] ra);
      write_en   = we;
      write_addr = wa;
      write_data = wd;
      write_be   = be;
      read_en    = re;
      read_addr  = ra;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
   endtask

   initial begin
      rst        = 1'b1;
      write_en   = 1'b0;
      write_addr = 4'h0;
      write_data = 32'h0;
      write_be   = 4'h0;
      read_en    = 1'b0;
      read_addr  = 4'h0;
      repeat (3) tick();
      rst = 1'b0;
      idle(16);

      // Every address reads back zero after the clear.
      for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(i));
      idle(3);

      // Partial-lane overwrite of address 3.
      apply_stimulus(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, 4'h0);
      apply_stimulus(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'h0);
      apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd3);
      idle(3);

      // Same-cycle write and read of address 5.
      apply_stimulus(1'b1, 4'd5, 32'hFFFFFFFF, 4'b1111, 1'b1, 4'd5);
      apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd5);
      idle(3);

      // Back-to-back reads of 0, 1, 2 after distinct writes.
      apply_stimulus(1'b1, 4'd0, 32'h01010101, 4'b1111, 1'b0, 4'h0);
      apply_stimulus(1'b1, 4'd1, 32'h02020202, 4'b1111, 1'b0, 4'h0);
      apply_stimulus(1'b1, 4'd2, 32'h03030303, 4'b1111, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(i));
      idle(3);

      // Address 13 is past the end of the 12-word instance.
      apply_stimulus(1'b1, 4'd13, 32'h12345678, 4'b1111, 1'b0, 4'h0);
      apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd13);
      idle(3);

      // Randomized traffic, biased toward same-address collisions.
      for (int n = 0; n < 400; n++) begin
         logic [3:0] ra;
         logic [3:0] wa;
         ra = 4'($urandom_range(0, 15));
         wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
         apply_stimulus(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), ra);
      end
      idle(3);

      // Reset right behind a read: the pending two-cycle read must vanish.
      apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd1);
      rst = 1'b1;
      apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd2);
      rst = 1'b0;
      idle(7);

      // Reset again with the clear counter at 7, then a write while busy.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      apply_stimulus(1'b1, 4'd2, 32'hDEADBEEF, 4'b1111, 1'b0, 4'h0);
      idle(15);
      apply_stimulus(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'd2);
      idle(5);

      cmp("pending_reads", 0, 32'(exp_q0.size()), 32'h0);
      cmp("pending_reads", 1, 32'(exp_q1.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
